btn_route_w_sw: RTL and testbench

//  Command-side counterpart of the watch/stopwatch display mux. Turns debounced

---
 rtl/btn_route_w_sw.sv | 111 +++++++++++
 tb/tb_btn_route_w_sw.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/btn_route_w_sw.sv
// Button edge router: one-cycle command pulses to the stopwatch or the watch.
// Optional hold-to-repeat in watch mode when AUTO_REPEAT_EN is defined.
module btn_route_w_sw #(
  parameter int NBTN          = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_btn_mode,
  input  logic [NBTN-1:0] i_btn,
  output logic            o_sel,
  output logic [NBTN-1:0] o_sw_btn,
  output logic [NBTN-1:0] o_w_btn,
  output logic            o_mode_pend
);

  typedef enum logic {RUN, PEND} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NBTN-1:0] prev_btn;
  logic [NBTN-1:0] rise;
  logic [NBTN-1:0] rpt;
  logic            prev_mode;
  logic            mode_rise;
  logic            idle;
  logic            sel_nxt;

  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_cfg_chk
    $error("btn_route_w_sw: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  assign rise      = i_btn & ~prev_btn;
  assign mode_rise = i_btn_mode & ~prev_mode;
  assign idle      = (i_btn == '0);

  // A toggle only lands while no command button is down.
  always_comb begin
    state_nxt = state;
    sel_nxt   = o_sel;
    unique case (state)
      RUN: begin
        if (mode_rise) begin
          if (idle) sel_nxt = ~o_sel;
          else      state_nxt = PEND;
        end
      end
      PEND: begin
        if (idle) begin
          sel_nxt   = ~o_sel;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      o_sel       <= 1'b0;
      o_mode_pend <= 1'b0;
      o_sw_btn    <= '0;
      o_w_btn     <= '0;
      prev_btn    <= '1;
      prev_mode   <= 1'b1;
    end else begin
      state       <= state_nxt;
      o_sel       <= sel_nxt;
      o_mode_pend <= (state_nxt == PEND);
      o_sw_btn    <= o_sel ? '0 : rise;
      o_w_btn     <= o_sel ? (rise | rpt) : '0;
      prev_btn    <= i_btn;
      prev_mode   <= i_btn_mode;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] DLY    = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          arm;
  logic          single;
  logic          held;

  assign single  = o_sel & $onehot(i_btn);
  assign held    = single & arm & (i_btn == prev_btn);
  assign cnt_inc = cnt + CW'(1);
  assign rpt     = (held && cnt_inc == DLY) ? i_btn : '0;

  // Reloading to DELAY-PERIOD makes later repeats reuse the same compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      arm <= 1'b0;
    end else if (held) begin
      cnt <= (cnt_inc == DLY) ? RELOAD : cnt_inc;
    end else begin
      cnt <= '0;
      arm <= single & (rise == i_btn);
    end
  end
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_btn_route_w_sw.sv
// Bench for btn_route_w_sw: directed cases then random presses vs a model.
module tb_btn_route_w_sw;

  localparam int NB = 4;
`ifdef AUTO_REPEAT_EN
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int HOLD_PULSES = 4;
`else
  localparam int RD = 50_000_000;
  localparam int RP = 10_000_000;
  localparam int HOLD_PULSES = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_mode = 1'b0;
  logic [NB-1:0] btn = '0;
  logic          sel;
  logic          mode_pend;
  logic [NB-1:0] sw_btn;
  logic [NB-1:0] w_btn;

  btn_route_w_sw #(
    .NBTN(NB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_btn_mode(btn_mode),
    .i_btn(btn),
    .o_sel(sel),
    .o_sw_btn(sw_btn),
    .o_w_btn(w_btn),
    .o_mode_pend(mode_pend)
  );

  always #5 clk = ~clk;

  logic [NB-1:0] m_prev = '1;
  logic          m_prevm = 1'b1;
  logic          m_sel = 1'b0;
  logic          m_pend = 1'b0;
  int            m_hold = -1;
  logic [NB-1:0] e_sw = '0;
  logic [NB-1:0] e_w = '0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  int            pulses;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what one clock edge does, from the behavioural rules.
  task automatic model_edge(input logic [NB-1:0] b, input logic m,
                            input logic r);
    logic [NB-1:0] rs;
    logic          mr;
    if (r) begin
      m_prev = '1; m_prevm = 1'b1; m_sel = 1'b0; m_pend = 1'b0;
      m_hold = -1; e_sw = '0; e_w = '0;
      return;
    end
    rs   = b & ~m_prev;
    mr   = m & ~m_prevm;
    e_sw = m_sel ? '0 : rs;
    e_w  = m_sel ? rs : '0;
`ifdef AUTO_REPEAT_EN
    if (m_sel && $onehot(b)) begin
      if (b == m_prev && m_hold >= 0) begin
        m_hold++;
        if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0))
          e_w = e_w | b;
      end else if (rs == b) m_hold = 0;
      else m_hold = -1;
    end else m_hold = -1;
`endif
    if (!m_pend) begin
      if (mr) begin
        if (b == '0) m_sel = ~m_sel;
        else m_pend = 1'b1;
      end
    end else if (b == '0) begin
      m_sel  = ~m_sel;
      m_pend = 1'b0;
    end
    m_prev  = b;
    m_prevm = m;
  endtask

  task automatic step(input logic [NB-1:0] b, input logic m,
                      input logic r, input string tag);
    btn = b; btn_mode = m; reset = r;
    @(posedge clk);
    model_edge(b, m, r);
    #1;
    check(tag, {6'd0, sel, mode_pend, sw_btn, w_btn},
               {6'd0, m_sel, m_pend, e_sw, e_w});
  endtask

  initial begin
    logic [NB-1:0] rb;
    logic          rm;
    logic          rr;
    // held through reset: no pulse until released and pressed again
    step(4'b0001, 1'b0, 1'b1, "rst0");
    step(4'b0001, 1'b0, 1'b1, "rst1");
    check("rst_out", {sel, mode_pend, sw_btn, w_btn}, 16'd0);
    step(4'b0001, 1'b0, 1'b0, "held0");
    step(4'b0001, 1'b0, 1'b0, "held1");
    step(4'b0000, 1'b0, 1'b0, "rel");
    step(4'b0001, 1'b0, 1'b0, "t1_press");
    check("t1_sw", 16'(sw_btn), 16'h1);
    check("t1_w", 16'(w_btn), 16'h0);
    step(4'b0001, 1'b0, 1'b0, "t1_once");
    check("t1_gone", 16'(sw_btn), 16'h0);
    step(4'b0000, 1'b0, 1'b0, "t1_rel");
    // idle mode press toggles to watch
    step(4'b0000, 1'b1, 1'b0, "t2_mode");
    check("t2_sel", 16'(sel), 16'h1);
    step(4'b0000, 1'b0, 1'b0, "t2_mrel");
    step(4'b0100, 1'b0, 1'b0, "t2_press");
    check("t2_w", 16'(w_btn), 16'h4);
    check("t2_sw", 16'(sw_btn), 16'h0);
    step(4'b0100, 1'b0, 1'b0, "t2_once");
    step(4'b0000, 1'b0, 1'b0, "t2_rel");
    step(4'b0000, 1'b1, 1'b0, "back_sw");
    check("back_sel", 16'(sel), 16'h0);
    step(4'b0000, 1'b0, 1'b0, "back_rel");
    // toggle held off while a button is down
    step(4'b0010, 1'b0, 1'b0, "t3_hold");
    step(4'b0010, 1'b1, 1'b0, "t3_mode");
    check("t3_pend", {15'd0, mode_pend}, 16'h1);
    check("t3_sel0", 16'(sel), 16'h0);
    step(4'b0010, 1'b0, 1'b0, "t3_wait");
    step(4'b0010, 1'b1, 1'b0, "t3_ign");
    step(4'b0000, 1'b0, 1'b0, "t3_rel");
    check("t3_done", {sel, mode_pend, sw_btn, w_btn}, 16'h200);
    step(4'b0000, 1'b0, 1'b0, "t3_idle");
    check("t3_one", 16'(sel), 16'h1);
    step(4'b0000, 1'b1, 1'b0, "t4_pre");
    step(4'b0000, 1'b0, 1'b0, "t4_pre2");
    // mode and btn0 rise together
    step(4'b0001, 1'b1, 1'b0, "t4_both");
    check("t4_sw", 16'(sw_btn), 16'h1);
    check("t4_pend", {sel, mode_pend}, 16'h1);
    step(4'b0001, 1'b0, 1'b0, "t4_hold");
    step(4'b0000, 1'b0, 1'b0, "t4_rel");
    check("t4_sel", {sel, mode_pend}, 16'h2);
    step(4'b0000, 1'b0, 1'b0, "t5_idle");
    // hold btn3 for 20 cycles in watch mode
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b1000, 1'b0, 1'b0, "t5_hold");
      if (w_btn == 4'b1000) pulses++;
    end
    check("t5_pulses", 16'(pulses), 16'(HOLD_PULSES));
    step(4'b0000, 1'b0, 1'b0, "t5_rel");
    // reset while a toggle is pending
    step(4'b0010, 1'b0, 1'b0, "t6_hold");
    step(4'b0010, 1'b1, 1'b0, "t6_mode");
    check("t6_pend", {15'd0, mode_pend}, 16'h1);
    step(4'b0010, 1'b0, 1'b1, "t6_rst");
    check("t6_clr", {sel, mode_pend, sw_btn, w_btn}, 16'd0);
    step(4'b0000, 1'b0, 1'b0, "t6_rel");
    check("t6_sel", {sel, mode_pend}, 16'h0);
    // random presses against the model
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = NB'($urandom);
      if ($urandom_range(0, 3) == 0) rb = '0;
      if ($urandom_range(0, 2) == 0) rb = NB'(1 << $urandom_range(0, NB - 1));
      rm = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rb, rm, rr, "rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
